// File: rtl/arb3_pkg.sv
// ---------------------------------------------------------------------------
// arb3_pkg : shared types and helpers for the 3-way round-robin arbiter
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package arb3_pkg;

  localparam int NUM_REQ = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  typedef logic [1:0] id_t;

  function automatic id_t next_idx(input id_t i);
    return (i == 2'd2) ? 2'd0 : id_t'(i + 2'd1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_pick3.sv
// ---------------------------------------------------------------------------
// rr_pick3 : combinational round-robin pick over three request lines
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rr_pick3
  import arb3_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_i,
  input  id_t                last_owner_i,
  output logic               found_o,
  output id_t                winner_o
);

  id_t cand0;
  id_t cand1;
  id_t cand2;

  // The previous owner is searched last, so it only wins when nobody else asks.
  assign cand0 = next_idx(last_owner_i);
  assign cand1 = next_idx(cand0);
  assign cand2 = next_idx(cand1);

  always_comb begin
    found_o  = 1'b0;
    winner_o = cand0;
    if (req_i[cand0]) begin
      found_o  = 1'b1;
      winner_o = cand0;
    end else if (req_i[cand1]) begin
      found_o  = 1'b1;
      winner_o = cand1;
    end else if (req_i[cand2]) begin
      found_o  = 1'b1;
      winner_o = cand2;
    end
  end

endmodule

`default_nettype wire

// File: rtl/rr_arbiter_3.sv
// ---------------------------------------------------------------------------
// rr_arbiter_3 : 3-requester round-robin arbiter with hold limit and dead cycle
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rr_arbiter_3
  import arb3_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [1:0]         gnt_id,
  output logic               busy,
  output logic               any_req,
  output logic               expired
);

  localparam int                CNT_W     = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_t             state_q, state_d;
  id_t                owner_q, owner_d;
  id_t                last_q, last_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  id_t                gnt_id_q, gnt_id_d;
  logic               busy_q, busy_d;
  logic               expired_q, expired_d;

  logic               pick_found;
  id_t                pick_id;

  rr_pick3 u_pick (
    .req_i        (req),
    .last_owner_i (last_q),
    .found_o      (pick_found),
    .winner_o     (pick_id)
  );

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    expired_d = 1'b0;

    case (state_q)
      IDLE, RELEASE: begin
        if (pick_found) begin
          state_d = GRANT;
          owner_d = pick_id;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        cnt_d = cnt_q + 1'b1;
        // A dropped request takes precedence over the hold limit, so no pulse then.
        if (!req[owner_q]) begin
          state_d = RELEASE;
          last_d  = owner_q;
        end else if (cnt_q == HOLD_LAST) begin
          state_d   = RELEASE;
          last_d    = owner_q;
          expired_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    gnt_d    = '0;
    gnt_id_d = '0;
    busy_d   = 1'b0;
    if (state_d == GRANT) begin
      gnt_d    = NUM_REQ'(1) << owner_d;
      gnt_id_d = owner_d;
      busy_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      owner_q   <= 2'd0;
      last_q    <= 2'd2;
      cnt_q     <= '0;
      gnt_q     <= '0;
      gnt_id_q  <= 2'd0;
      busy_q    <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      gnt_q     <= gnt_d;
      gnt_id_q  <= gnt_id_d;
      busy_q    <= busy_d;
      expired_q <= expired_d;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_id  = gnt_id_q;
  assign busy    = busy_q;
  assign expired = expired_q;
  assign any_req = |req;

endmodule

`default_nettype wire

// File: tb/tb_rr_arbiter_3.sv
// ---------------------------------------------------------------------------
// tb_rr_arbiter_3 : directed self-checking bench for rr_arbiter_3
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_rr_arbiter_3;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] req8  = 3'b000;
  logic [2:0] req2  = 3'b000;

  logic [2:0] gnt8, gnt2;
  logic [1:0] id8, id2;
  logic       busy8, busy2, any8, any2, exp8, exp2;

  int n_cmp   = 0;
  int n_err   = 0;
  int inv_cmp = 0;
  int inv_err = 0;

  logic [2:0] p_req8 = 3'b000, p_gnt8 = 3'b000, p_req2 = 3'b000, p_gnt2 = 3'b000;

  always #5 clk = ~clk;

  rr_arbiter_3 #(.MAX_HOLD(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .req(req8), .gnt(gnt8), .gnt_id(id8),
    .busy(busy8), .any_req(any8), .expired(exp8)
  );

  rr_arbiter_3 #(.MAX_HOLD(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .req(req2), .gnt(gnt2), .gnt_id(id2),
    .busy(busy2), .any_req(any2), .expired(exp2)
  );

  // Values seen by the DUT at each rising edge, for the drop-release invariant.
  always @(posedge clk) begin
    p_req8 = req8;
    p_gnt8 = gnt8;
    p_req2 = req2;
    p_gnt2 = gnt2;
  end

  always @(negedge clk) begin
    inv_cmp++;
    if (!$onehot0(gnt8)) begin inv_err++; $display("FAIL onehot8: gnt=%b", gnt8); end
    inv_cmp++;
    if (busy8 !== (|gnt8)) begin inv_err++; $display("FAIL busy8: busy=%b gnt=%b", busy8, gnt8); end
    inv_cmp++;
    if ((gnt8 & p_gnt8 & ~p_req8) !== 3'b000)
      begin inv_err++; $display("FAIL drop8: gnt=%b prev_gnt=%b prev_req=%b", gnt8, p_gnt8, p_req8); end
    inv_cmp++;
    if (!$onehot0(gnt2)) begin inv_err++; $display("FAIL onehot2: gnt=%b", gnt2); end
    inv_cmp++;
    if (busy2 !== (|gnt2)) begin inv_err++; $display("FAIL busy2: busy=%b gnt=%b", busy2, gnt2); end
    inv_cmp++;
    if ((gnt2 & p_gnt2 & ~p_req2) !== 3'b000)
      begin inv_err++; $display("FAIL drop2: gnt=%b prev_gnt=%b prev_req=%b", gnt2, p_gnt2, p_req2); end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    req8  = 3'b000;
    req2  = 3'b000;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({gnt8, id8, busy8, any8, exp8} !== 8'b0) begin
        n_err++;
        $display("FAIL reset_idle c%0d: gnt=%b id=%0d busy=%b any_req=%b expired=%b, want all 0",
                 k, gnt8, id8, busy8, any8, exp8);
      end
    end
  endtask

  task automatic test_rotation();
    logic [2:0] eg;
    logic [1:0] eid;
    logic       eb, ee;
    int         phase, own;
    do_reset();
    req8 = 3'b111;
    // 8 grant cycles then one expired dead cycle per owner, rotating 0,1,2,0.
    for (int k = 1; k <= 31; k++) begin
      @(negedge clk);
      phase = (k - 1) % 9;
      own   = ((k - 1) / 9) % 3;
      if (phase < 8) begin
        eg = 3'b001 << own; eid = own[1:0]; eb = 1'b1; ee = 1'b0;
      end else begin
        eg = 3'b000; eid = 2'd0; eb = 1'b0; ee = 1'b1;
      end
      n_cmp++;
      if ({gnt8, id8, busy8, exp8} !== {eg, eid, eb, ee}) begin
        n_err++;
        $display("FAIL rotation c%0d: gnt=%b id=%0d busy=%b expired=%b, want gnt=%b id=%0d busy=%b expired=%b",
                 k, gnt8, id8, busy8, exp8, eg, eid, eb, ee);
      end
    end
    n_cmp++;
    if (any8 !== 1'b1) begin n_err++; $display("FAIL any_req_high: got %b want 1", any8); end
    req8 = 3'b000;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_single_drop();
    do_reset();
    req8 = 3'b010;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({gnt8, id8, busy8, exp8} !== {3'b010, 2'd1, 1'b1, 1'b0}) begin
        n_err++;
        $display("FAIL single_hold c%0d: gnt=%b id=%0d busy=%b expired=%b, want 010/1/1/0",
                 k, gnt8, id8, busy8, exp8);
      end
    end
    req8 = 3'b000;
    @(negedge clk);
    n_cmp++;
    if ({gnt8, busy8, exp8} !== 5'b0) begin
      n_err++;
      $display("FAIL single_drop: gnt=%b busy=%b expired=%b, want 000/0/0", gnt8, busy8, exp8);
    end
    @(negedge clk);
    n_cmp++;
    if ({gnt8, busy8, exp8, any8} !== 6'b0) begin
      n_err++;
      $display("FAIL single_idle: gnt=%b busy=%b expired=%b any_req=%b, want 0", gnt8, busy8, exp8, any8);
    end
  endtask

  task automatic test_glitch();
    do_reset();
    @(negedge clk);
    #1 req8 = 3'b010;
    #2 req8 = 3'b000;
    repeat (2) begin
      @(negedge clk);
      n_cmp++;
      if ({gnt8, busy8} !== 4'b0) begin
        n_err++;
        $display("FAIL glitch_ignored: gnt=%b busy=%b, want 000/0", gnt8, busy8);
      end
    end
  endtask

  task automatic test_pair();
    do_reset();
    req8 = 3'b101;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({gnt8, id8} !== {3'b001, 2'd0}) begin
        n_err++;
        $display("FAIL pair_first c%0d: gnt=%b id=%0d, want 001/0", k, gnt8, id8);
      end
    end
    req8 = 3'b100;
    @(negedge clk);
    n_cmp++;
    if ({gnt8, busy8, exp8} !== 5'b0) begin
      n_err++;
      $display("FAIL pair_dead: gnt=%b busy=%b expired=%b, want 000/0/0", gnt8, busy8, exp8);
    end
    @(negedge clk);
    n_cmp++;
    if ({gnt8, id8, busy8} !== {3'b100, 2'd2, 1'b1}) begin
      n_err++;
      $display("FAIL pair_second: gnt=%b id=%0d busy=%b, want 100/2/1", gnt8, id8, busy8);
    end
    req8 = 3'b000;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_hold_limit();
    logic [2:0] eg[6]  = '{3'b010, 3'b010, 3'b000, 3'b010, 3'b010, 3'b000};
    logic       ee[6]  = '{1'b0,   1'b0,   1'b1,   1'b0,   1'b0,   1'b0};
    do_reset();
    req2 = 3'b010;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({gnt2, exp2} !== {eg[k], ee[k]}) begin
        n_err++;
        $display("FAIL hold_limit c%0d: gnt=%b expired=%b, want %b/%b", k + 1, gnt2, exp2, eg[k], ee[k]);
      end
      // Drop on the last allowed cycle: the drop must win and suppress expired.
      if (k == 4) req2 = 3'b000;
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    req8 = 3'b110;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({gnt8, id8} !== {3'b010, 2'd1}) begin
      n_err++;
      $display("FAIL areset_pre: gnt=%b id=%0d, want 010/1", gnt8, id8);
    end
    req8 = 3'b111;
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({gnt8, id8, busy8, exp8} !== 7'b0) begin
      n_err++;
      $display("FAIL areset_now: gnt=%b id=%0d busy=%b expired=%b, want 0", gnt8, id8, busy8, exp8);
    end
    #1 rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({gnt8, id8, busy8} !== {3'b001, 2'd0, 1'b1}) begin
      n_err++;
      $display("FAIL areset_restart: gnt=%b id=%0d busy=%b, want 001/0/1", gnt8, id8, busy8);
    end
    req8 = 3'b000;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_single_drop();
    test_glitch();
    test_pair();
    test_hold_limit();
    test_async_reset();
    n_cmp += inv_cmp;
    n_err += inv_err;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
